// File: rtl/pc_ctrl.sv
// Program-counter register with branch decision, EPC capture and commit counter.
// Define PC_ALIGN_CHECK_EN to build in the misaligned-target trap (RUN -> TRAP -> vector).
module pc_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_00FC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_next,
   input  logic        pc_write,
   input  logic        pc_write_cond,
   input  logic [1:0]  branch_op,
   input  logic        zero,
   input  logic        neg,
   input  logic        epc_write,
   input  logic [31:0] epc_in,
   output logic [31:0] pc,
   output logic [31:0] epc,
   output logic        branch_taken,
   output logic        pc_updated,
   output logic        align_exc,
   output logic [31:0] pc_write_count
);

   typedef enum logic {RUN, TRAP} state_t;

   state_t      state;
   logic [31:0] count_q;
   logic        commit;
   logic        misaligned;

   always_comb begin
      branch_taken = 1'b0;
      case (branch_op)
         2'b00: branch_taken = zero;
         2'b01: branch_taken = !zero;
         2'b10: branch_taken = zero | neg;
         2'b11: branch_taken = !zero & !neg;
         default: branch_taken = 1'b0;
      endcase
   end

   assign commit = pc_write | (pc_write_cond & branch_taken);

`ifdef PC_ALIGN_CHECK_EN
   assign misaligned = (pc_next[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   assign pc_write_count = count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         pc         <= RESET_PC;
         epc        <= 32'h0;
         count_q    <= 32'h0;
         pc_updated <= 1'b0;
         align_exc  <= 1'b0;
      end else begin
         pc_updated <= 1'b0;
         align_exc  <= 1'b0;
         case (state)
            RUN: begin
               if (epc_write)
                  epc <= epc_in;
               // trap capture is written last so it overrides a same-cycle epc_write
               if (commit && misaligned) begin
                  epc       <= pc;
                  align_exc <= 1'b1;
                  state     <= TRAP;
               end else if (commit) begin
                  pc         <= pc_next;
                  pc_updated <= 1'b1;
                  count_q    <= count_q + 32'd1;
               end
            end
            TRAP: begin
               pc         <= TRAP_VECTOR;
               pc_updated <= 1'b1;
               count_q    <= count_q + 32'd1;
               state      <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed + randomized bench for pc_ctrl against a cycle-level reference model.
module tb_pc_ctrl;

   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR = 32'h0000_00FC;
`ifdef PC_ALIGN_CHECK_EN
   localparam bit ALIGN_ON = 1'b1;
`else
   localparam bit ALIGN_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_next;
   logic        pc_write, pc_write_cond;
   logic [1:0]  branch_op;
   logic        zero, neg;
   logic        epc_write;
   logic [31:0] epc_in;
   logic [31:0] pc, epc, pc_write_count;
   logic        branch_taken, pc_updated, align_exc;

   int tests  = 0;
   int failed = 0;

   // reference model state
   logic [31:0] m_pc, m_epc, m_count;
   logic        m_upd, m_exc;
   bit          m_trap_pending;

   pc_ctrl #(.RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VECTOR)) dut (
      .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .branch_op(branch_op), .zero(zero), .neg(neg),
      .epc_write(epc_write), .epc_in(epc_in), .pc(pc), .epc(epc),
      .branch_taken(branch_taken), .pc_updated(pc_updated), .align_exc(align_exc),
      .pc_write_count(pc_write_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Branch decision viewed as a comparison of the ALU result against zero.
   function automatic bit ref_taken(input logic [1:0] op, input logic z, input logic n);
      bit is_zero = z;
      bit is_lt   = n;
      case (op)
         2'd0:    return is_zero;
         2'd1:    return !is_zero;
         2'd2:    return is_zero || is_lt;
         default: return !(is_zero || is_lt);
      endcase
   endfunction

   task automatic model_reset();
      m_pc = RESET_PC; m_epc = 32'h0; m_count = 32'h0;
      m_upd = 1'b0; m_exc = 1'b0; m_trap_pending = 0;
   endtask

   task automatic model_clock();
      bit do_commit;
      m_upd = 1'b0; m_exc = 1'b0;
      if (m_trap_pending) begin
         m_pc = TRAP_VECTOR; m_upd = 1'b1; m_count = m_count + 1; m_trap_pending = 0;
      end else begin
         do_commit = pc_write || (pc_write_cond && ref_taken(branch_op, zero, neg));
         if (epc_write) m_epc = epc_in;
         if (do_commit && ALIGN_ON && (pc_next % 4 != 0)) begin
            m_epc = m_pc; m_exc = 1'b1; m_trap_pending = 1;
         end else if (do_commit) begin
            m_pc = pc_next; m_upd = 1'b1; m_count = m_count + 1;
         end
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".epc"}, epc, m_epc);
      check({tag, ".count"}, pc_write_count, m_count);
      check({tag, ".pc_updated"}, {31'h0, pc_updated}, {31'h0, m_upd});
      check({tag, ".align_exc"}, {31'h0, align_exc}, {31'h0, m_exc});
   endtask

   // Called at a negedge with inputs already applied.
   task automatic step(input string tag);
      #1 check({tag, ".branch_taken"}, {31'h0, branch_taken},
               {31'h0, ref_taken(branch_op, zero, neg)});
      model_clock();
      @(posedge clk);
      @(negedge clk);
      check_state(tag);
   endtask

   task automatic drive(input logic w, input logic wc, input logic [1:0] op, input logic z,
                        input logic n, input logic [31:0] nxt, input logic ew,
                        input logic [31:0] ein);
      pc_write = w; pc_write_cond = wc; branch_op = op; zero = z; neg = n;
      pc_next = nxt; epc_write = ew; epc_in = ein;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      check_state("reset");
      @(negedge clk);
      reset = 1'b0;

      // unconditional write of an aligned target
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 32'h0);
      step("write4");
      check("write4.pc_abs", pc, 32'h0000_0004);
      check("write4.count_abs", pc_write_count, 32'd1);

      // bne with zero=1: not taken
      drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_0040, 1'b0, 32'h0);
      step("bne_nt");
      check("bne_nt.pc_abs", pc, 32'h0000_0004);

      // each branch op taken once
      drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h0); step("beq_t");
      drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0); step("blez_t");
      drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0000_0300, 1'b0, 32'h0); step("bgtz_t");
      drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0); step("bgtz_nt");

      // epc_write alone in RUN
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678); step("epcw");

      // misaligned target from pc=0x10
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 32'h0); step("pc10");
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0022, 1'b0, 32'h0); step("mis");
      // inputs during TRAP must be ignored
      drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_0080, 1'b1, 32'h5555_5555); step("trap");
      if (ALIGN_ON) check("trap.vector_abs", pc, 32'h0000_00FC);

      // misaligned commit together with epc_write: trap capture wins
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 32'h0); step("pc10b");
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0022, 1'b1, 32'hAAAA_AAAA); step("mis_epcw");
      if (ALIGN_ON) check("mis_epcw.epc_abs", epc, 32'h0000_0010);
      idle(); step("mis_epcw_vec");

      // counter wrap
      force dut.count_q = 32'hFFFF_FFFF;
      #1 release dut.count_q;
      m_count = 32'hFFFF_FFFF;
      check("preload.count", pc_write_count, m_count);
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0020, 1'b0, 32'h0); step("wrap");
      check("wrap.count_abs", pc_write_count, 32'h0);

      // reset asserted while in TRAP (or right after a normal load without the check)
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0033, 1'b0, 32'h0); step("mis_rst");
      idle();
      reset = 1'b1;
      model_reset();
      #1 check_state("async_rst");
      @(negedge clk);
      reset = 1'b0;
      step("post_rst");
      check("post_rst.pc_abs", pc, RESET_PC);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         logic [31:0] nx;
         nx = $urandom;
         if ($urandom_range(3) != 0) nx[1:0] = 2'b00;
         drive($urandom_range(2) == 0, $urandom_range(1) == 1, 2'($urandom_range(3)),
               $urandom_range(1) == 1, $urandom_range(1) == 1, nx,
               $urandom_range(3) == 0, $urandom);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_00FC: PC target on alignment trap.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port pc_next, input, 32: candidate next PC from the PC-source selector.
REQ-006 SHALL have port pc_write, input, 1: unconditional PC update request.
REQ-007 SHALL have port pc_write_cond, input, 1: conditional (branch) PC update request.
REQ-008 SHALL have port branch_op, input, 2: 00 beq, 01 bne, 10 blez, 11 bgtz.
REQ-009 SHALL have port zero, input, 1: ALU result zero flag.
REQ-010 SHALL have port neg, input, 1: ALU result sign bit.
REQ-011 SHALL have port epc_write, input, 1: control-unit request to capture epc_in.
REQ-012 SHALL have port epc_in, input, 32: value to capture into EPC.
REQ-013 SHALL have port pc, output, 32: current PC register.
REQ-014 SHALL have port epc, output, 32: exception PC register, feeds selector EPC input.
REQ-015 SHALL have port branch_taken, output, 1: combinational branch decision.
REQ-016 SHALL have port pc_updated, output, 1: registered one-cycle pulse after any PC load.
REQ-017 SHALL have port align_exc, output, 1: registered, high for the whole TRAP state.
REQ-018 SHALL have port pc_write_count, output, 32: count of committed PC loads.

Function
REQ-019 branch_taken SHALL be: beq zero; bne !zero; blez zero|neg; bgtz !zero&!neg.
REQ-020 Commit request SHALL be pc_write | (pc_write_cond & branch_taken); pc_write wins when both high.
REQ-021 FSM SHALL have states RUN and TRAP; reset state RUN.
REQ-022 In RUN, commit with pc_next[1:0]==0 SHALL load pc<=pc_next next edge, pulse pc_updated, increment pc_write_count.
REQ-023 In RUN, commit with pc_next[1:0]!=0 SHALL leave pc unchanged, load epc<=pc, go to TRAP.
REQ-024 In TRAP (exactly one cycle) SHALL load pc<=TRAP_VECTOR, pulse pc_updated, increment count, return to RUN.
REQ-025 In TRAP, pc_write, pc_write_cond and epc_write SHALL be ignored.
REQ-026 epc_write in RUN SHALL load epc<=epc_in; if same cycle as REQ-023 trap, trap capture wins.
REQ-027 No commit in RUN SHALL hold pc, epc, count; pc_updated low.
REQ-028 pc_write_count SHALL wrap 32'hFFFF_FFFF -> 0 silently.
REQ-029 Latency: request cycle N -> pc valid and pc_updated high in cycle N+1.

Reset
REQ-030 reset SHALL immediately, independent of clk, set pc=RESET_PC, epc=0, pc_write_count=0, pc_updated=0, align_exc=0, state RUN.
REQ-031 Reset asserted during TRAP SHALL abort the trap; no vector load after release.

Configuration
REQ-032 Macro PC_ALIGN_CHECK_EN SHALL compile in REQ-023/024 alignment trap.
REQ-033 Without PC_ALIGN_CHECK_EN: any commit loads pc_next unmodified, TRAP never entered, align_exc tied 0.

Verification
REQ-034 Reset, pc_write=1 pc_next=0x0000_0004 -> next cycle pc=0x4, pc_updated=1, count=1.
REQ-035 pc_write_cond=1, branch_op=01, zero=1, pc_next=0x40 -> branch_taken=0, pc unchanged, count unchanged.
REQ-036 pc=0x10, pc_write=1 pc_next=0x0000_0022 (macro on) -> epc=0x10, align_exc 1 cycle, then pc=0xFC.
REQ-037 Same as REQ-036 with epc_write=1 epc_in=0xAAAA_AAAA same cycle -> epc=0x10.
REQ-038 Preload count 0xFFFF_FFFF, pc_write=1 -> count=0; reset asserted mid-TRAP -> pc=RESET_PC, align_exc=0.
